sevenseg_ctrl: RTL and testbench

Memory-mapped controller for the `sevenseg` display driver. It sits on the picosoc `iomem` bus and owns the 24-bit `data` word fed to `sevenseg`. It arbitrates that word between CPU register writes and a hardware override requester (boot/diag source), and sequences blanking and blinking. `sevenseg` keeps doing digit multiplexing; this block only decides what value it shows.

---
 rtl/sevenseg_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_sevenseg_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_ctrl.sv
// Memory-mapped controller that owns the 24-bit word shown by the sevenseg driver.
// Arbitrates that word between CPU register writes and a hardware override source.
module sevenseg_ctrl #(
    parameter logic [31:0] ADDR_BASE   = 32'h0300_0000,
    parameter logic [23:0] BLINK_DIV   = 24'd5_000_000,
    parameter logic [26:0] OVR_HOLD    = 27'd100_000_000,
    parameter logic [23:0] BLANK_VALUE = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    input  logic        ovr_valid,
    input  logic [23:0] ovr_data,
    output logic        ovr_ack,
    output logic [23:0] data
);

    typedef enum logic {
        NORMAL,
        OVR
    } arbState_e;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    arbState_e   state_q, state_d;
    logic [26:0] hold_q, hold_d;
    logic [23:0] ovrLatch_q, ovrLatch_d;
    logic        ovrAck_q, ovrAck_d;

    logic [23:0] dataReg_q, dataReg_d;
    logic        ctrlEn_q, ctrlEn_d;
    logic        ctrlBlink_q, ctrlBlink_d;
    logic        ctrlOvrEn_q, ctrlOvrEn_d;

    logic [23:0] blinkCnt_q, blinkCnt_d;
    logic        phase_q, phase_d;

    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic [23:0] dispData_q, dispData_d;

    logic        busHit;
    logic        busMatch;
    logic        busWrite;
    logic [1:0]  regSel;
    logic        ovrCancel;
    logic        ovrAccept;
    logic        unusedBits;

    assign busHit   = (iomem_addr[31:4] == ADDR_BASE[31:4]);
    assign busMatch = iomem_valid && busHit && !ready_q;
    assign busWrite = busMatch && (iomem_wstrb != 4'b0000);
    assign regSel   = iomem_addr[3:2];

    // Clearing ovr_en through CTRL wins over any same-cycle override request.
    assign ovrCancel = busWrite && (regSel == REG_CTRL) && iomem_wstrb[0] && !iomem_wdata[2];
    assign ovrAccept = ovr_valid && ctrlOvrEn_q && !ovrAck_q && !ovrCancel;

    assign unusedBits = ^{iomem_addr[1:0], iomem_wdata[31:24], iomem_wstrb[3]};

    always_comb begin
        dataReg_d   = dataReg_q;
        ctrlEn_d    = ctrlEn_q;
        ctrlBlink_d = ctrlBlink_q;
        ctrlOvrEn_d = ctrlOvrEn_q;
        if (busWrite && (regSel == REG_DATA)) begin
            if (iomem_wstrb[0]) dataReg_d[7:0]   = iomem_wdata[7:0];
            if (iomem_wstrb[1]) dataReg_d[15:8]  = iomem_wdata[15:8];
            if (iomem_wstrb[2]) dataReg_d[23:16] = iomem_wdata[23:16];
        end
        if (busWrite && (regSel == REG_CTRL) && iomem_wstrb[0]) begin
            ctrlEn_d    = iomem_wdata[0];
            ctrlBlink_d = iomem_wdata[1];
            ctrlOvrEn_d = iomem_wdata[2];
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        ovrLatch_d = ovrLatch_q;
        ovrAck_d   = 1'b0;
        case (state_q)
            NORMAL: begin
                if (ovrAccept) begin
                    state_d    = OVR;
                    hold_d     = OVR_HOLD - 27'd1;
                    ovrLatch_d = ovr_data;
                    ovrAck_d   = 1'b1;
                end
            end
            OVR: begin
                if (ovrCancel) begin
                    state_d = NORMAL;
                    hold_d  = 27'd0;
                end else if (ovrAccept) begin
                    hold_d     = OVR_HOLD - 27'd1;
                    ovrLatch_d = ovr_data;
                    ovrAck_d   = 1'b1;
                end else if (hold_q == 27'd0) begin
                    state_d = NORMAL;
                end else begin
                    hold_d = hold_q - 27'd1;
                end
            end
            default: begin
                state_d = NORMAL;
                hold_d  = 27'd0;
            end
        endcase
    end

    // Holding the counter at zero while blink is off makes blinking start visible.
    always_comb begin
        blinkCnt_d = blinkCnt_q;
        phase_d    = phase_q;
        if (!ctrlBlink_q) begin
            blinkCnt_d = 24'd0;
            phase_d    = 1'b0;
        end else if (blinkCnt_q == BLINK_DIV - 24'd1) begin
            blinkCnt_d = 24'd0;
            phase_d    = !phase_q;
        end else begin
            blinkCnt_d = blinkCnt_q + 24'd1;
        end
    end

    always_comb begin
        dispData_d = dataReg_q;
        if (!ctrlEn_q) begin
            dispData_d = BLANK_VALUE;
        end else if (state_q == OVR) begin
            dispData_d = ovrLatch_q;
        end else if (ctrlBlink_q && phase_q) begin
            dispData_d = BLANK_VALUE;
        end
    end

    // Read data reflects register contents as they stand in the acknowledge cycle.
    always_comb begin
        ready_d = busMatch;
        rdata_d = 32'd0;
        if (busMatch) begin
            case (regSel)
                REG_DATA:   rdata_d = {8'h00, dataReg_d};
                REG_CTRL:   rdata_d = {29'd0, ctrlOvrEn_d, ctrlBlink_d, ctrlEn_d};
                REG_STATUS: rdata_d = {30'd0, phase_d, (state_d == OVR)};
                default:    rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= NORMAL;
            hold_q      <= 27'd0;
            ovrLatch_q  <= 24'd0;
            ovrAck_q    <= 1'b0;
            dataReg_q   <= 24'd0;
            ctrlEn_q    <= 1'b1;
            ctrlBlink_q <= 1'b0;
            ctrlOvrEn_q <= 1'b1;
            blinkCnt_q  <= 24'd0;
            phase_q     <= 1'b0;
            ready_q     <= 1'b0;
            rdata_q     <= 32'd0;
            dispData_q  <= 24'd0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            ovrLatch_q  <= ovrLatch_d;
            ovrAck_q    <= ovrAck_d;
            dataReg_q   <= dataReg_d;
            ctrlEn_q    <= ctrlEn_d;
            ctrlBlink_q <= ctrlBlink_d;
            ctrlOvrEn_q <= ctrlOvrEn_d;
            blinkCnt_q  <= blinkCnt_d;
            phase_q     <= phase_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            dispData_q  <= dispData_d;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign ovr_ack     = ovrAck_q;
    assign data        = dispData_q;

endmodule

// File: tb/tb_sevenseg_ctrl.sv
// Bench for sevenseg_ctrl: register table, hand-written timing sequences, and a
// randomized run checked every cycle against a timestamp-based reference model.
module tb_sevenseg_ctrl;

    localparam logic [31:0] BASE  = 32'h0300_0000;
    localparam int          DIV   = 4;
    localparam int          HOLD  = 8;
    localparam logic [23:0] BLANK = 24'hFFFFFF;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = 32'h0;
    logic [31:0] iomem_wdata = 32'h0;
    logic [31:0] iomem_rdata;
    logic        ovr_valid = 1'b0;
    logic [23:0] ovr_data = 24'h0;
    logic        ovr_ack;
    logic [23:0] data;

    always #5 clk = ~clk;

    sevenseg_ctrl #(
        .ADDR_BASE  (BASE),
        .BLINK_DIV  (24'd4),
        .OVR_HOLD   (27'd8),
        .BLANK_VALUE(BLANK)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr (iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata),
        .ovr_valid  (ovr_valid),
        .ovr_data   (ovr_data),
        .ovr_ack    (ovr_ack),
        .data       (data)
    );

    int vecCount = 0;
    int missCount = 0;
    int cyc = 0;

    // Reference model: override lifetime is tracked as the last cycle it is shown
    // to the arbiter, and blink phase is derived from the cycle blink turned on.
    logic [23:0] mDataReg = 24'h0;
    logic [23:0] mOvrVal = 24'h0;
    logic [23:0] mOut = 24'h0;
    logic        mEn = 1'b1;
    logic        mBlink = 1'b0;
    logic        mOvrEn = 1'b1;
    logic        mReady = 1'b0;
    logic        mAck = 1'b0;
    logic [31:0] mRdata = 32'h0;
    int          mOvrLast = -1;
    int          mBlinkSince = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        expReady;
        logic [31:0] expRdata;
        logic [23:0] expData;
    } busVec_t;

    busVec_t vecs[12];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic phaseAt(input int c, input logic on, input int since);
        if (!on) return 1'b0;
        return ((((c - since) / DIV) % 2) != 0);
    endfunction

    // Advance one clock: predict from the current inputs, then compare after the edge.
    task automatic tick();
        logic [23:0] nData, nOvrVal, nOut;
        logic        nEn, nBlink, nOvrEn, nReady, nAck, curPhase, nxtPhase;
        logic [31:0] nRdata;
        int          nOvrLast, nSince;
        logic        hit, wr, cancel, accept;
        nData = mDataReg; nOvrVal = mOvrVal; nEn = mEn; nBlink = mBlink; nOvrEn = mOvrEn;
        nOvrLast = mOvrLast; nSince = mBlinkSince;
        curPhase = phaseAt(cyc, mBlink, mBlinkSince);
        if (!mEn) nOut = BLANK;
        else if (cyc <= mOvrLast) nOut = mOvrVal;
        else if (mBlink && curPhase) nOut = BLANK;
        else nOut = mDataReg;
        hit = iomem_valid && (iomem_addr[31:4] == BASE[31:4]) && !mReady;
        wr = hit && (iomem_wstrb != 4'h0);
        if (wr && iomem_addr[3:2] == 2'd0)
            for (int b = 0; b < 3; b++)
                if (iomem_wstrb[b]) nData[8*b +: 8] = iomem_wdata[8*b +: 8];
        if (wr && iomem_addr[3:2] == 2'd1 && iomem_wstrb[0]) begin
            nEn = iomem_wdata[0]; nBlink = iomem_wdata[1]; nOvrEn = iomem_wdata[2];
        end
        cancel = wr && iomem_addr[3:2] == 2'd1 && iomem_wstrb[0] && !iomem_wdata[2];
        accept = ovr_valid && mOvrEn && !mAck && !cancel;
        if (accept) begin
            nOvrLast = cyc + HOLD;
            nOvrVal = ovr_data;
        end else if (cancel && nOvrLast > cyc) begin
            nOvrLast = cyc;
        end
        nAck = accept;
        if (nBlink && !mBlink) nSince = cyc + 1;
        nxtPhase = phaseAt(cyc + 1, nBlink, nSince);
        nReady = hit;
        nRdata = 32'h0;
        if (hit) begin
            case (iomem_addr[3:2])
                2'd0: nRdata = {8'h00, nData};
                2'd1: nRdata = {29'd0, nOvrEn, nBlink, nEn};
                2'd2: nRdata = {30'd0, nxtPhase, (nOvrLast >= cyc + 1)};
                default: nRdata = 32'h0;
            endcase
        end
        if (!resetn) begin
            nData = 24'h0; nOvrVal = 24'h0; nOut = 24'h0; nEn = 1'b1; nBlink = 1'b0;
            nOvrEn = 1'b1; nReady = 1'b0; nAck = 1'b0; nRdata = 32'h0; nOvrLast = -1;
        end
        @(posedge clk);
        #1;
        mDataReg = nData; mOvrVal = nOvrVal; mOut = nOut; mEn = nEn; mBlink = nBlink;
        mOvrEn = nOvrEn; mReady = nReady; mAck = nAck; mRdata = nRdata;
        mOvrLast = nOvrLast; mBlinkSince = nSince;
        cyc++;
        checkOutput("iomem_ready", 32'(iomem_ready), 32'(mReady));
        checkOutput("iomem_rdata", iomem_rdata, mRdata);
        checkOutput("ovr_ack", 32'(ovr_ack), 32'(mAck));
        checkOutput("data", {8'h00, data}, {8'h00, mOut});
    endtask

    // One bus transfer: hold valid until ready (bounded), then one idle cycle.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st,
                                 output logic gotReady, output logic [31:0] gotRdata, output int lat);
        iomem_addr = addr; iomem_wdata = wd; iomem_wstrb = st; iomem_valid = 1'b1;
        gotReady = 1'b0; gotRdata = 32'h0; lat = 0;
        for (int k = 1; k <= 4 && !gotReady; k++) begin
            tick();
            if (iomem_ready) begin
                gotReady = 1'b1; gotRdata = iomem_rdata; lat = k;
            end
        end
        iomem_valid = 1'b0; iomem_wstrb = 4'h0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, vectors %0d", vecCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        r;
        logic [31:0] rd;
        int          lat;
        int          busAge;

        vecs[0]  = '{BASE + 32'h4,  32'h0,         4'h0, 1'b1, 32'h0000_0005, 24'h000000};
        vecs[1]  = '{BASE + 32'h8,  32'h0,         4'h0, 1'b1, 32'h0000_0000, 24'h000000};
        vecs[2]  = '{BASE,          32'h00FF_5511, 4'hF, 1'b1, 32'h00FF_5511, 24'hFF5511};
        vecs[3]  = '{BASE,          32'h0,         4'h0, 1'b1, 32'h00FF_5511, 24'hFF5511};
        vecs[4]  = '{BASE,          32'h0000_AA00, 4'h2, 1'b1, 32'h00FF_AA11, 24'hFFAA11};
        vecs[5]  = '{BASE,          32'h0,         4'h0, 1'b1, 32'h00FF_AA11, 24'hFFAA11};
        vecs[6]  = '{BASE + 32'hC,  32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0000_0000, 24'hFFAA11};
        vecs[7]  = '{BASE + 32'hC,  32'h0,         4'h0, 1'b1, 32'h0000_0000, 24'hFFAA11};
        vecs[8]  = '{BASE,          32'h7700_0000, 4'h8, 1'b1, 32'h00FF_AA11, 24'hFFAA11};
        vecs[9]  = '{BASE + 32'h20, 32'h0,         4'h0, 1'b0, 32'h0000_0000, 24'hFFAA11};
        vecs[10] = '{BASE + 32'h20, 32'h0000_0000, 4'hF, 1'b0, 32'h0000_0000, 24'hFFAA11};
        vecs[11] = '{BASE + 32'h4,  32'hFFFF_FFF5, 4'hF, 1'b1, 32'h0000_0005, 24'hFFAA11};

        resetn = 1'b0;
        tick();
        tick();
        checkOutput("resetReady", 32'(iomem_ready), 32'd0);
        checkOutput("resetAck", 32'(ovr_ack), 32'd0);
        checkOutput("resetData", {8'h00, data}, 32'h0);
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, r, rd, lat);
            checkOutput("tblReady", 32'(r), 32'(vecs[i].expReady));
            checkOutput("tblRdata", rd, vecs[i].expRdata);
            if (vecs[i].expReady) checkOutput("tblLatency", lat, 1);
            checkOutput("tblData", {8'h00, data}, {8'h00, vecs[i].expData});
        end

        applyStimulus(BASE + 32'h4, 32'h3, 4'h1, r, rd, lat);
        for (int k = 0; k < 16; k++) begin
            checkOutput("blinkData", {8'h00, data}, {8'h00, (((k / DIV) % 2) != 0) ? BLANK : 24'hFFAA11});
            tick();
        end
        applyStimulus(BASE + 32'h4, 32'h1, 4'h1, r, rd, lat);
        for (int k = 0; k < 6; k++) begin
            checkOutput("steadyData", {8'h00, data}, 32'h00FF_AA11);
            tick();
        end
        applyStimulus(BASE + 32'h4, 32'h0, 4'h1, r, rd, lat);
        checkOutput("disabledData", {8'h00, data}, {8'h00, BLANK});
        applyStimulus(BASE + 32'h4, 32'h5, 4'h1, r, rd, lat);

        ovr_data = 24'h123456; ovr_valid = 1'b1;
        tick();
        checkOutput("ovrAckPulse", 32'(ovr_ack), 32'd1);
        ovr_valid = 1'b0;
        iomem_addr = BASE + 32'h8; iomem_wstrb = 4'h0;
        for (int c = 2; c <= 11; c++) begin
            iomem_valid = (c == 4);
            tick();
            checkOutput("ovrData", {8'h00, data}, (c <= HOLD + 1) ? 32'h0012_3456 : 32'h00FF_AA11);
            if (c == 2) checkOutput("ovrAckLow", 32'(ovr_ack), 32'd0);
            if (c == 4) checkOutput("ovrStatus", 32'(iomem_rdata[0]), 32'd1);
        end
        iomem_valid = 1'b0;

        ovr_data = 24'h123456; ovr_valid = 1'b1;
        tick();
        checkOutput("retrigFirstAck", 32'(ovr_ack), 32'd1);
        ovr_valid = 1'b0;
        for (int c = 2; c <= 15; c++) begin
            if (c == 6) begin
                ovr_valid = 1'b1; ovr_data = 24'h654321;
            end else begin
                ovr_valid = 1'b0;
            end
            tick();
            if (c == 6) checkOutput("retrigAck", 32'(ovr_ack), 32'd1);
            checkOutput("retrigData", {8'h00, data},
                        (c <= 6) ? 32'h0012_3456 : (c <= 14) ? 32'h0065_4321 : 32'h00FF_AA11);
        end
        ovr_valid = 1'b0;

        applyStimulus(BASE + 32'h4, 32'h1, 4'h1, r, rd, lat);
        ovr_data = 24'hABCDEF; ovr_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checkOutput("gatedAck", 32'(ovr_ack), 32'd0);
            checkOutput("gatedData", {8'h00, data}, 32'h00FF_AA11);
        end
        iomem_addr = BASE + 32'h4; iomem_wdata = 32'h5; iomem_wstrb = 4'h1; iomem_valid = 1'b1;
        tick();
        iomem_valid = 1'b0; iomem_wstrb = 4'h0;
        tick();
        checkOutput("enableAck", 32'(ovr_ack), 32'd1);
        ovr_valid = 1'b0;
        tick();
        checkOutput("enableData", {8'h00, data}, 32'h00AB_CDEF);
        iomem_wdata = 32'h1; iomem_wstrb = 4'h1; iomem_valid = 1'b1;
        ovr_data = 24'h111111; ovr_valid = 1'b1;
        tick();
        checkOutput("cancelAck", 32'(ovr_ack), 32'd0);
        iomem_valid = 1'b0; iomem_wstrb = 4'h0;
        tick();
        checkOutput("cancelData", {8'h00, data}, 32'h00FF_AA11);
        applyStimulus(BASE + 32'h8, 32'h0, 4'h0, r, rd, lat);
        checkOutput("cancelStatus", rd, 32'h0);
        applyStimulus(BASE + 32'h4, 32'h5, 4'h1, r, rd, lat);
        checkOutput("reenableAck", 32'(ovr_ack), 32'd1);
        ovr_valid = 1'b0;
        tick();
        tick();
        checkOutput("pendingOvrData", {8'h00, data}, 32'h0011_1111);
        resetn = 1'b0;
        tick();
        checkOutput("midOvrResetData", {8'h00, data}, 32'h0);
        checkOutput("midOvrResetAck", 32'(ovr_ack), 32'd0);
        resetn = 1'b1;
        tick();
        tick();
        checkOutput("postResetData", {8'h00, data}, 32'h0);
        applyStimulus(BASE + 32'h8, 32'h0, 4'h0, r, rd, lat);
        checkOutput("postResetStatus", rd, 32'h0);

        iomem_addr = BASE + 32'h4; iomem_wstrb = 4'h0; iomem_valid = 1'b1; resetn = 1'b0;
        tick();
        checkOutput("resetXferReady", 32'(iomem_ready), 32'd0);
        resetn = 1'b1;
        tick();
        checkOutput("pendingXferReady", 32'(iomem_ready), 32'd1);
        checkOutput("pendingXferRdata", iomem_rdata, 32'h5);
        iomem_valid = 1'b0;
        tick();

        busAge = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!iomem_valid && $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: iomem_addr = BASE;
                    3, 4, 5: iomem_addr = BASE + 32'h4;
                    6, 7:    iomem_addr = BASE + 32'h8;
                    8:       iomem_addr = BASE + 32'hC;
                    default: iomem_addr = BASE + 32'h20;
                endcase
                iomem_wstrb = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
                iomem_wdata = $urandom;
                if (iomem_addr[3:2] == 2'd1) iomem_wdata[0] = ($urandom_range(0, 4) != 0);
                iomem_valid = 1'b1;
                busAge = 0;
            end
            if (!ovr_valid && $urandom_range(0, 5) == 0) begin
                ovr_valid = 1'b1;
                ovr_data = 24'($urandom);
            end
            resetn = ($urandom_range(0, 199) != 0);
            tick();
            if (iomem_valid) begin
                busAge++;
                if (iomem_ready || busAge > 3) begin
                    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
                end
            end
            if (ovr_ack) ovr_valid = 1'b0;
        end
        resetn = 1'b1;
        iomem_valid = 1'b0;
        ovr_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
